// File: rtl/des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// des_key_sched_seq
//
// Sequential DES round-key generator for an iterative DES datapath.
// A 64-bit key is loaded on start and reduced to the 56-bit C||D register
// through PC-1. Round keys are then offered one at a time through PC-2 on a
// valid/ready interface. Encrypt order is K1..K_ROUNDS. Decrypt order is
// K_ROUNDS..K1.
//
// In decrypt mode the walk starts from C||D of the last round. When the total
// rotation over all rounds is a multiple of 28, that register equals PC-1 of
// the key, so no preparation is needed. Otherwise a PRE phase of ROUNDS cycles
// rotates forward first.
//
// Parameters:
//   ROUNDS     number of round keys generated (1..16)
//   ROT_SCHED  bit r-1 set  -> round r rotates by 1, clear -> rotates by 2
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   key_in   64-bit DES key, DES bit 1 = key_in[63] (parity bits ignored)
//   mode     0 = encrypt order, 1 = decrypt order (sampled with start)
//   start    load request, honoured only when idle
//   busy     high while preparing or generating keys
//   k_out    PC-2 of the current C||D, valid while k_valid
//   k_idx    round number of k_out (1..ROUNDS)
//   k_valid  round key offered
//   k_ready  consumer accepts k_out when k_valid && k_ready
//   done     one-cycle pulse in the cycle after the last key is accepted
//   cd_out   current C||D register (C = [55:28])
// -----------------------------------------------------------------------------
module des_key_sched_seq #(
    parameter int          ROUNDS    = 16,
    parameter logic [15:0] ROT_SCHED = 16'h8103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        start,
    output logic        busy,
    output logic [47:0] k_out,
    output logic [4:0]  k_idx,
    output logic        k_valid,
    input  logic        k_ready,
    output logic        done,
    output logic [55:0] cd_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_GEN  = 2'd2
    } state_t;

    // PC-1: output bit i (DES numbering, 1-based) takes key bit PC1_TAB[i-1]
    localparam logic [5:0] PC1_TAB [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC-2: round-key bit i takes C||D bit PC2_TAB[i-1]
    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Total rotation over all generated rounds, evaluated at elaboration
    function automatic int tot_rot_f();
        int          t;
        logic [15:0] s;
        t = 0;
        s = ROT_SCHED;
        for (int r = 0; r < ROUNDS; r++) begin
            t = t + (s[0] ? 1 : 2);
            s = s >> 1;
        end
        return t;
    endfunction

    localparam int         TOT  = tot_rot_f();
    localparam logic       WRAP = ((TOT % 28) == 0);
    localparam logic [4:0] LAST = 5'(ROUNDS);

    // DES bit n (1-based, MSB first) of a 64-bit word is word[64-n]; with a
    // 6-bit index, 0 - n wraps to exactly 64 - n.
    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  i;
        logic [5:0]  src;
        r = 56'd0;
        for (i = 6'd0; i < 6'd56; i = i + 6'd1) begin
            src            = PC1_TAB[i];
            r[6'd55 - i]   = k[6'd0 - src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  i;
        logic [5:0]  src;
        r = 48'd0;
        for (i = 6'd0; i < 6'd48; i = i + 6'd1) begin
            src            = PC2_TAB[i];
            r[6'd47 - i]   = cd[6'd56 - src];
        end
        return r;
    endfunction

    // True when round r (1-based) rotates by two positions
    function automatic logic rot_two_f(input logic [4:0] r);
        logic [4:0] m;
        m = r - 5'd1;
        return ~ROT_SCHED[m[3:0]];
    endfunction

    function automatic logic [27:0] rotl28_f(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28_f(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // C and D halves rotate independently
    function automatic logic [55:0] rotl56_f(input logic [55:0] cd, input logic two);
        return {rotl28_f(cd[55:28], two), rotl28_f(cd[27:0], two)};
    endfunction

    function automatic logic [55:0] rotr56_f(input logic [55:0] cd, input logic two);
        return {rotr28_f(cd[55:28], two), rotr28_f(cd[27:0], two)};
    endfunction

    state_t      state_r;
    logic [55:0] cd_r;
    logic [4:0]  k_idx_r;
    logic        k_valid_r;
    logic        done_r;
    logic        mode_r;

    logic [55:0] cd_load_s;
    logic [55:0] cd_first_s;
    logic [55:0] cd_fwd_s;
    logic [55:0] cd_enc_s;
    logic [55:0] cd_dec_s;
    logic        xfer_s;

    // Candidate next values of C||D for every state transition
    always_comb begin
        cd_load_s  = pc1_f(key_in);
        cd_first_s = rotl56_f(cd_load_s, rot_two_f(5'd1));
        cd_fwd_s   = rotl56_f(cd_r, rot_two_f(k_idx_r));
        cd_enc_s   = rotl56_f(cd_r, rot_two_f(k_idx_r + 5'd1));
        cd_dec_s   = rotr56_f(cd_r, rot_two_f(k_idx_r));
        xfer_s     = k_valid_r & k_ready;
    end

    // Control FSM and key-schedule state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cd_r      <= 56'd0;
            k_idx_r   <= 5'd0;
            k_valid_r <= 1'b0;
            done_r    <= 1'b0;
            mode_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        if (!mode) begin
                            cd_r      <= cd_first_s;
                            k_idx_r   <= 5'd1;
                            k_valid_r <= 1'b1;
                            state_r   <= ST_GEN;
                        end else if (WRAP) begin
                            // C||D after the last round equals PC-1 of the key
                            cd_r      <= cd_load_s;
                            k_idx_r   <= LAST;
                            k_valid_r <= 1'b1;
                            state_r   <= ST_GEN;
                        end else begin
                            cd_r      <= cd_load_s;
                            k_idx_r   <= 5'd1;
                            state_r   <= ST_PRE;
                        end
                    end
                end
                ST_PRE: begin
                    // Walk forward to C||D of the last round before offering keys
                    cd_r <= cd_fwd_s;
                    if (k_idx_r == LAST) begin
                        k_valid_r <= 1'b1;
                        state_r   <= ST_GEN;
                    end else begin
                        k_idx_r <= k_idx_r + 5'd1;
                    end
                end
                ST_GEN: begin
                    if (xfer_s) begin
                        if (!mode_r) begin
                            if (k_idx_r == LAST) begin
                                k_valid_r <= 1'b0;
                                done_r    <= 1'b1;
                                state_r   <= ST_IDLE;
                            end else begin
                                cd_r    <= cd_enc_s;
                                k_idx_r <= k_idx_r + 5'd1;
                            end
                        end else begin
                            if (k_idx_r == 5'd1) begin
                                k_valid_r <= 1'b0;
                                done_r    <= 1'b1;
                                state_r   <= ST_IDLE;
                            end else begin
                                // Undo the rotation that produced the current round
                                cd_r    <= cd_dec_s;
                                k_idx_r <= k_idx_r - 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    k_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; k_out is PC-2 of the register with no added latency
    always_comb begin
        busy    = (state_r != ST_IDLE);
        k_out   = pc2_f(cd_r);
        k_idx   = k_idx_r;
        k_valid = k_valid_r;
        done    = done_r;
        cd_out  = cd_r;
    end

endmodule

// File: tb/tb_des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// tb_des_key_sched_seq
//
// Self-checking bench for des_key_sched_seq. Two instances are used: the
// default 16-round schedule and an 8-round variant. Expected round keys come
// from a bit-array reference model of the DES key schedule (PC-1, per-round
// left rotations, PC-2). A table of {key, mode, options, expected first/last
// key} rows drives the sequences. Hand-written steps cover the boundary cases:
// start during GEN, start in the done cycle, and reset mid-GEN.
// -----------------------------------------------------------------------------
module tb_des_key_sched_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        mode;
    logic        st;
    logic        sel;
    logic        k_ready;

    logic        start16, busy16, k_valid16, done16;
    logic [47:0] k_out16;
    logic [4:0]  k_idx16;
    logic [55:0] cd_out16;

    logic        start8, busy8, k_valid8, done8;
    logic [47:0] k_out8;
    logic [4:0]  k_idx8;
    logic [55:0] cd_out8;

    logic        obs_busy, obs_valid, obs_done;
    logic [47:0] obs_kout;
    logic [4:0]  obs_idx;
    logic [55:0] obs_cd;

    always #5 clk = ~clk;

    assign start16   = st & ~sel;
    assign start8    = st & sel;
    assign obs_busy  = sel ? busy8    : busy16;
    assign obs_valid = sel ? k_valid8 : k_valid16;
    assign obs_done  = sel ? done8    : done16;
    assign obs_kout  = sel ? k_out8   : k_out16;
    assign obs_idx   = sel ? k_idx8   : k_idx16;
    assign obs_cd    = sel ? cd_out8  : cd_out16;

    des_key_sched_seq dut (
        .clk(clk), .rst(rst), .key_in(key_in), .mode(mode), .start(start16),
        .busy(busy16), .k_out(k_out16), .k_idx(k_idx16), .k_valid(k_valid16),
        .k_ready(k_ready), .done(done16), .cd_out(cd_out16)
    );

    des_key_sched_seq #(.ROUNDS(8), .ROT_SCHED(16'h8103)) dut8 (
        .clk(clk), .rst(rst), .key_in(key_in), .mode(mode), .start(start8),
        .busy(busy8), .k_out(k_out8), .k_idx(k_idx8), .k_valid(k_valid8),
        .k_ready(k_ready), .done(done8), .cd_out(cd_out8)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model (DES bit numbering, 1-based) ----------
    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
                       59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,
                       31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                       26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                       51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic [47:0] ref_k  [1:16];
    logic [55:0] ref_cd [0:16];

    task automatic model(input logic [63:0] key);
        bit          kb [1:64];
        bit          cb [1:56];
        bit          t;
        logic [47:0] kk;
        logic [55:0] cc;
        for (int i = 1; i <= 64; i++) kb[i] = key[64 - i];
        for (int i = 1; i <= 56; i++) cb[i] = kb[pc1_t[i - 1]];
        for (int r = 0; r <= 16; r++) begin
            if (r > 0) begin
                for (int s = 0; s < shifts[r - 1]; s++) begin
                    t = cb[1];
                    for (int j = 1; j <= 27; j++) cb[j] = cb[j + 1];
                    cb[28] = t;
                    t = cb[29];
                    for (int j = 29; j <= 55; j++) cb[j] = cb[j + 1];
                    cb[56] = t;
                end
                for (int i = 1; i <= 48; i++) kk[48 - i] = cb[pc2_t[i - 1]];
                ref_k[r] = kk;
            end
            for (int i = 1; i <= 56; i++) cc[56 - i] = cb[i];
            ref_cd[r] = cc;
        end
    endtask

    typedef struct {
        logic [63:0] key;
        logic        md;
        int          nr;
        bit          stall;
        bit          poke;
        bit          chain;
        logic [47:0] exp_first;
        logic [4:0]  exp_fidx;
        logic [47:0] exp_last;
        logic [55:0] exp_cd;
    } vec_t;

    vec_t tbl [9];

    task automatic fill_row(input logic [63:0] key, input logic md, input int nr,
                            input bit stall, output vec_t v);
        int fi;
        model(key);
        fi          = md ? nr : 1;
        v.key       = key;
        v.md        = md;
        v.nr        = nr;
        v.stall     = stall;
        v.poke      = 1'b0;
        v.chain     = 1'b0;
        v.exp_first = ref_k[fi];
        v.exp_fidx  = 5'(fi);
        v.exp_last  = ref_k[md ? 1 : nr];
        v.exp_cd    = ref_cd[fi];
    endtask

    // Apply one row: start, optional PRE, drain all keys, check done/latency
    task automatic run(input vec_t v);
        int          e, got, n, tot, limit;
        bit          pre, seen, abort;
        logic [47:0] first_k, last_k;
        logic [4:0]  first_i;
        logic [55:0] first_cd;
        model(v.key);
        tot = 0;
        for (int r = 0; r < v.nr; r++) tot += shifts[r];
        pre   = v.md && ((tot % 28) != 0);
        limit = 4 * v.nr + 40;
        sel   = (v.nr == 8);
        first_k = '0; last_k = '0; first_i = '0; first_cd = '0;
        @(negedge clk);
        key_in = v.key; mode = v.md; st = 1'b1; k_ready = 1'b0;
        @(negedge clk);
        st = 1'b0;
        n  = 1;
        if (pre) begin
            for (int p = 1; p <= v.nr; p++) begin
                chk("pre_valid", 64'(obs_valid), 64'd0);
                chk("pre_busy", 64'(obs_busy), 64'd1);
                @(negedge clk);
                n++;
            end
        end
        e = v.md ? v.nr : 1;
        got = 0; seen = 1'b0; abort = 1'b0;
        while (got < v.nr && n < limit && !abort) begin
            if (obs_valid) begin
                chk("k_idx", 64'(obs_idx), 64'(e));
                chk("k_out", 64'(obs_kout), 64'(ref_k[e]));
                chk("cd_out", 64'(obs_cd), 64'(ref_cd[e]));
                if (!seen) begin
                    first_k = obs_kout; first_i = obs_idx; first_cd = obs_cd; seen = 1'b1;
                end
                k_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                if (k_ready) begin
                    last_k = obs_kout;
                    got++;
                    e = v.md ? e - 1 : e + 1;
                end
            end else begin
                chk("gen_valid", 64'(obs_valid), 64'd1);
                abort = 1'b1;
            end
            // A start pulse with a different key/mode mid-run must be ignored
            if (v.poke && got == 3) begin
                st = 1'b1; key_in = ~v.key; mode = ~v.md;
            end else begin
                st = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        st = 1'b0;
        chk("keys_taken", 64'(got), 64'(v.nr));
        chk("done_pulse", 64'(obs_done), 64'd1);
        chk("valid_end", 64'(obs_valid), 64'd0);
        chk("busy_end", 64'(obs_busy), 64'd0);
        if (!v.stall) chk("latency", 64'(n), 64'(pre ? 2 * v.nr + 1 : v.nr + 1));
        chk("first_key", 64'(first_k), 64'(v.exp_first));
        chk("first_idx", 64'(first_i), 64'(v.exp_fidx));
        chk("first_cd", 64'(first_cd), 64'(v.exp_cd));
        chk("last_key", 64'(last_k), 64'(v.exp_last));
        k_ready = 1'b0;
        if (v.chain) begin
            // Start in the done cycle is accepted, then reset lands mid-GEN
            key_in = v.key; mode = 1'b0; st = 1'b1;
            @(negedge clk);
            st = 1'b0;
            chk("chain_valid", 64'(obs_valid), 64'd1);
            chk("chain_idx", 64'(obs_idx), 64'd1);
            chk("chain_key", 64'(obs_kout), 64'(ref_k[1]));
            k_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("chain_idx3", 64'(obs_idx), 64'd3);
            #2 rst = 1'b1;
            #1;
            chk("rst_valid", 64'(obs_valid), 64'd0);
            chk("rst_busy", 64'(obs_busy), 64'd0);
            chk("rst_idx", 64'(obs_idx), 64'd0);
            chk("rst_kout", 64'(obs_kout), 64'd0);
            chk("rst_cd", 64'(obs_cd), 64'd0);
            chk("rst_done", 64'(obs_done), 64'd0);
            k_ready = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("post_rst_done", 64'(obs_done), 64'd0);
            chk("post_rst_busy", 64'(obs_busy), 64'd0);
        end else begin
            @(negedge clk);
            chk("done_once", 64'(obs_done), 64'd0);
            chk("cd_retained", 64'(obs_cd), 64'(ref_cd[v.md ? 1 : v.nr]));
        end
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; sel = 1'b0; k_ready = 1'b0; key_in = 64'd0; mode = 1'b0;

        // Known-answer rows, then derived and randomized rows
        tbl[0] = '{64'h133457799BBCDFF1, 1'b0, 16, 1'b0, 1'b0, 1'b0,
                   48'h1B02EFFC7072, 5'd1, 48'hCB3D8B0E17F5, 56'hE19955FAACCF1E};
        tbl[1] = '{64'h133457799BBCDFF1, 1'b1, 16, 1'b0, 1'b0, 1'b0,
                   48'hCB3D8B0E17F5, 5'd16, 48'h1B02EFFC7072, 56'hF0CCAAF556678F};
        tbl[2] = tbl[0]; tbl[2].stall = 1'b1;
        tbl[3] = tbl[1]; tbl[3].stall = 1'b1; tbl[3].poke = 1'b1; tbl[3].chain = 1'b1;
        fill_row({$urandom, $urandom}, 1'($urandom_range(0, 1)), 16, 1'b1, tbl[4]);
        fill_row({$urandom, $urandom}, 1'b1, 16, 1'b0, tbl[5]);
        fill_row(64'h133457799BBCDFF1, 1'b1, 8, 1'b0, tbl[6]);
        tbl[6].exp_last = 48'h1B02EFFC7072;
        fill_row(64'h133457799BBCDFF1, 1'b0, 8, 1'b0, tbl[7]);
        fill_row({$urandom, $urandom}, 1'b1, 8, 1'b1, tbl[8]);

        #12;
        chk("reset_busy", 64'(busy16), 64'd0);
        chk("reset_valid", 64'(k_valid16), 64'd0);
        chk("reset_idx", 64'(k_idx16), 64'd0);
        chk("reset_done", 64'(done16), 64'd0);
        chk("reset_kout", 64'(k_out16), 64'd0);
        chk("reset_cd", 64'(cd_out16), 64'd0);
        chk("reset_valid8", 64'(k_valid8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 9; r++) run(tbl[r]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential, parametrised DES round-key generator.
- Loads a 64-bit key and applies PC-1.
- Emits round keys K1..K_ROUNDS (encrypt) or K_ROUNDS..K1 (decrypt), one per accepted valid/ready transfer, each through PC-2.
- Feeds the iterative DES datapath, replacing the per-round combinational key-schedule instance; adds reduced-round support via a configurable rotation schedule.

Parameters:
- ROUNDS, 16: number of round keys generated, 1..16.
- ROT_SCHED, 16'h8103: bit r-1 = 1 means round r rotates by 1; 0 means rotate by 2. Default is the standard DES schedule.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  64  DES key; bit 1 (DES numbering) = key_in[63]; parity bits ignored.
- mode  input  1  0 = encrypt order, 1 = decrypt order; sampled with start.
- start  input  1  load request; honoured only in IDLE.
- busy  output  1  high in PRE or GEN.
- k_out  output  48  PC-2(cd); valid while k_valid.
- k_idx  output  5  round number of k_out, 1..ROUNDS.
- k_valid  output  1  round key offered.
- k_ready  input  1  consumer accepts k_out when k_valid && k_ready.
- done  output  1  one-cycle pulse, cycle after last key accepted.
- cd_out  output  56  current C||D register (C = [55:28]).

Behaviour:
- Reset (async, any state):
  - State = IDLE; cd = 0; k_idx = 0; k_valid = 0; busy = 0; done = 0.
  - k_out therefore = PC-2(0) = 0.
- Helpers:
  - sh(r) = 1 if ROT_SCHED[r-1], else 2.
  - rotl/rotr rotate C and D independently, 28 bits each.
  - TOT = sum of sh(1..ROUNDS), evaluated at compile time.
- IDLE:
  - start=1 with mode=0: cd <= rotl(PC1(key_in), sh(1)); k_idx <= 1; k_valid <= 1; -> GEN.
  - start=1 with mode=1 and TOT mod 28 == 0: cd <= PC1(key_in); k_idx <= ROUNDS; k_valid <= 1; -> GEN.
  - start=1 with mode=1 otherwise: cd <= PC1(key_in); k_idx <= 1; -> PRE.
- PRE (decrypt, non-wrapping schedule only):
  - Each cycle: cd <= rotl(cd, sh(k_idx)).
  - When k_idx == ROUNDS: k_valid <= 1, -> GEN (k_idx stays ROUNDS). Otherwise k_idx++.
  - Takes ROUNDS cycles. k_valid = 0 throughout.
- GEN:
  - k_out = PC-2(cd), combinational from the register (no extra latency).
  - No transfer: cd, k_idx, k_valid all hold; k_out stable under stall.
  - On transfer, encrypt:
    - If k_idx == ROUNDS: k_valid <= 0; done <= 1; -> IDLE.
    - Else: cd <= rotl(cd, sh(k_idx+1)); k_idx++.
  - On transfer, decrypt:
    - If k_idx == 1: k_valid <= 0; done <= 1; -> IDLE.
    - Else: cd <= rotr(cd, sh(k_idx)); k_idx--.
  - Back-to-back transfers with k_ready held high give one key per cycle.
- Latency:
  - start to first k_valid: 1 cycle (encrypt, or decrypt with wrapping schedule).
  - Decrypt with non-wrapping schedule: ROUNDS+1 cycles.
- Boundary conditions:
  - start while busy: ignored; mode and key_in are not resampled.
  - start in the same cycle as the done pulse: accepted (already in IDLE).
  - ROUNDS=1: a single key, K1, in either mode.
  - cd_out retains the final value after done.
  - rst asserted mid-GEN: k_valid drops immediately (async); no done pulse.
- busy = (state != IDLE); done is registered.

Test Plan:
- Encrypt vector:
  - key_in=64'h133457799BBCDFF1, mode=0, k_ready=1 -> cd_out after load = rotl(56'hF0CCAAF556678F,1).
  - k_out=48'h1B02EFFC7072 with k_idx=1; 16th key = 48'hCB3D8B0E17F5.
  - done exactly 1 cycle after the 16th transfer; 17 cycles start->done.
- Decrypt vector: same key, mode=1 -> first key = 48'hCB3D8B0E17F5 with k_idx=16, no PRE; last key = 48'h1B02EFFC7072 with k_idx=1.
- Back-pressure:
  - k_ready toggled pseudo-randomly -> sequence identical to the unstalled run.
  - k_out/k_idx stable while k_valid && !k_ready.
  - No key skipped or duplicated.
- Reduced rounds, ROUNDS=8:
  - Decrypt -> 8 PRE cycles with k_valid=0.
  - Then keys K8..K1 equal the encrypt-mode K8..K1 from the same key.
- Control hazards:
  - start pulsed during GEN -> ignored.
  - rst pulsed mid-GEN -> all outputs to reset values same cycle; next start runs a clean full sequence.
